// File: rtl/wb_gpio_bank_pkg.sv
// Shared definitions for the Wishbone GPIO bank: register offsets, port stride,
// register-select enum and the byte-select expansion helper.
package wb_gpio_pkg;

    localparam logic [7:0] OFS_OUT      = 8'h00;
    localparam logic [7:0] OFS_OE       = 8'h04;
    localparam logic [7:0] OFS_IN       = 8'h08;
    localparam logic [7:0] OFS_IRQ_EN   = 8'h0C;
    localparam logic [7:0] OFS_IRQ_RISE = 8'h10;
    localparam logic [7:0] OFS_IRQ_PEND = 8'h14;
    localparam logic [7:0] OFS_OUT_SET  = 8'h18;
    localparam logic [7:0] OFS_OUT_CLR  = 8'h1C;

    localparam logic [31:0] PORT_STRIDE = 32'h20;

    typedef enum logic [2:0] {
        REG_OUT      = 3'(OFS_OUT >> 2),
        REG_OE       = 3'(OFS_OE >> 2),
        REG_IN       = 3'(OFS_IN >> 2),
        REG_IRQ_EN   = 3'(OFS_IRQ_EN >> 2),
        REG_IRQ_RISE = 3'(OFS_IRQ_RISE >> 2),
        REG_IRQ_PEND = 3'(OFS_IRQ_PEND >> 2),
        REG_OUT_SET  = 3'(OFS_OUT_SET >> 2),
        REG_OUT_CLR  = 3'(OFS_OUT_CLR >> 2)
    } reg_sel_e;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_gpio_bank_if.sv
// Wishbone B4 classic bus bundle between the crossbar (master) and the GPIO bank (slave).
interface wb_gpio_bank_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_gpio_bank_port.sv
// One GPIO port: output/enable registers, input synchroniser, edge detector and
// pending interrupt bits. Writes are pre-gated by the bank's decode and byte selects.
module gpio_port
    import wb_gpio_pkg::*;
#(
    parameter int PORT_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wr_en_i,
    input  reg_sel_e              reg_i,
    input  logic [31:0]           wr_data_i,
    input  logic [3:0]            wr_sel_i,
    input  logic [PORT_WIDTH-1:0] gpio_i,
    output logic [PORT_WIDTH-1:0] gpio_o,
    output logic [PORT_WIDTH-1:0] gpio_oe_o,
    output logic [31:0]           rd_data_o,
    output logic                  irq_o
);
    localparam int W = PORT_WIDTH;

    logic [W-1:0] out_q, out_d, oe_q, oe_d, en_q, en_d, rise_q, rise_d, pend_q, pend_d;
    logic [W-1:0] prev_q, sync_v, wmask, wdata, edge_hit;
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [31:0] mask32;

    assign mask32   = sel_mask(wr_sel_i);
    assign wmask    = wr_en_i ? mask32[W-1:0] : '0;
    assign wdata    = wr_data_i[W-1:0] & wmask;
    assign sync_v   = sync_q[SYNC_STAGES-1];
    assign edge_hit = en_q & ((rise_q & sync_v & ~prev_q) | (~rise_q & ~sync_v & prev_q));

    // A new edge is ORed in after the W1C so a same-cycle set always wins.
    always_comb begin
        out_d  = out_q;
        oe_d   = oe_q;
        en_d   = en_q;
        rise_d = rise_q;
        pend_d = pend_q | edge_hit;
        case (reg_i)
            REG_OUT:      out_d  = (out_q & ~wmask) | wdata;
            REG_OE:       oe_d   = (oe_q & ~wmask) | wdata;
            REG_IRQ_EN:   en_d   = (en_q & ~wmask) | wdata;
            REG_IRQ_RISE: rise_d = (rise_q & ~wmask) | wdata;
            REG_IRQ_PEND: pend_d = (pend_q & ~wdata) | edge_hit;
            REG_OUT_SET:  out_d  = out_q | wdata;
            REG_OUT_CLR:  out_d  = out_q & ~wdata;
            default:      ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_q  <= '0;
            oe_q   <= '0;
            en_q   <= '0;
            rise_q <= '0;
            pend_q <= '0;
            prev_q <= '0;
            sync_q <= '0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            en_q      <= en_d;
            rise_q    <= rise_d;
            pend_q    <= pend_d;
            prev_q    <= sync_v;
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (reg_i)
            REG_OUT:      rd_data_o[W-1:0] = out_q;
            REG_OE:       rd_data_o[W-1:0] = oe_q;
            REG_IN:       rd_data_o[W-1:0] = sync_v;
            REG_IRQ_EN:   rd_data_o[W-1:0] = en_q;
            REG_IRQ_RISE: rd_data_o[W-1:0] = rise_q;
            REG_IRQ_PEND: rd_data_o[W-1:0] = pend_q;
            default:      rd_data_o = '0;
        endcase
    end

    assign gpio_o    = out_q;
    assign gpio_oe_o = oe_q;
    assign irq_o     = |pend_q;
endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank top: address decode, ack/err generation and read mux.
// Define WB_GPIO_BANK_ERR_EN to terminate unmapped accesses and IN writes with wb_err_o.
module wb_gpio_bank
    import wb_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          NUM_PORTS   = 2,
    parameter int          PORT_WIDTH  = 32,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_n_i,
    wb_gpio_bank_if.slave                   wb,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_i,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_o,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe_o,
    output logic                            irq_o
);
    localparam logic [31:0] SPAN = 32'(NUM_PORTS) * PORT_STRIDE;

    logic [31:0] offset, rd_word, dat_q;
    logic        mapped, req, bad, ack_q, err_q;
    logic [2:0]  port_idx;
    reg_sel_e    reg_sel;
    logic [NUM_PORTS-1:0][31:0] rd_data;
    logic [NUM_PORTS-1:0]       port_irq;

    assign offset   = wb.wb_adr_i - BASE_ADDR;
    assign mapped   = (wb.wb_adr_i >= BASE_ADDR) && (offset < SPAN);
    assign port_idx = offset[7:5];
    assign reg_sel  = reg_sel_e'(offset[4:2]);
    // ack/err high blocks a new request, giving one transfer per two cycles.
    assign req      = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;

`ifdef WB_GPIO_BANK_ERR_EN
    assign bad = ~mapped | (wb.wb_we_i & (reg_sel == REG_IN));
`else
    assign bad = 1'b0;
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        gpio_port #(
            .PORT_WIDTH  (PORT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk_i     (wb_clk_i),
            .rst_n_i   (wb_rst_n_i),
            .wr_en_i   (req & wb.wb_we_i & ~bad & mapped & (port_idx == 3'(p))),
            .reg_i     (reg_sel),
            .wr_data_i (wb.wb_dat_i),
            .wr_sel_i  (wb.wb_sel_i),
            .gpio_i    (gpio_i[p*PORT_WIDTH +: PORT_WIDTH]),
            .gpio_o    (gpio_o[p*PORT_WIDTH +: PORT_WIDTH]),
            .gpio_oe_o (gpio_oe_o[p*PORT_WIDTH +: PORT_WIDTH]),
            .rd_data_o (rd_data[p]),
            .irq_o     (port_irq[p])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (port_idx == 3'(p)) rd_word = rd_data[p];
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req & ~bad;
            err_q <= req & bad;
            dat_q <= (req & ~bad & ~wb.wb_we_i & mapped) ? rd_word : '0;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign irq_o       = |port_irq;
endmodule

// File: tb/tb_wb_gpio_bank.sv
// Scoreboard bench for wb_gpio_bank: directed scenarios plus randomized traffic
// against a register-level reference model.
module tb_wb_gpio_bank;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int NP = 2;

    typedef struct {
        bit          err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] gpio_i, gpio_o, gpio_oe;
    logic        irq;

    int checks = 0;
    int failures = 0;
    exp_t sbq[$];

    logic [31:0] m_out[NP], m_oe[NP], m_en[NP], m_rise[NP], m_pend[NP], m_pins[NP];

    wb_gpio_bank_if wb();

    wb_gpio_bank dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (wb),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_oe_o  (gpio_oe),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every bus termination pops one expectation.
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (wb.wb_ack_o || wb.wb_err_o) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected ack=%0b err=%0b", wb.wb_ack_o, wb.wb_err_o);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_err", {63'd0, wb.wb_err_o}, {63'd0, e.err});
                check("sb_ack", {63'd0, wb.wb_ack_o}, {63'd0, !e.err});
                check("sb_data", {32'd0, wb.wb_dat_o}, {32'd0, e.dat});
            end
        end
        if (wb.wb_ack_o) check("ack_one_cycle", {63'd0, ack_prev}, 64'd0);
        ack_prev = wb.wb_ack_o;
    end

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (sel[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [31:0] model_read(input int p, input int r);
        case (r)
            0: return m_out[p];
            1: return m_oe[p];
            2: return m_pins[p];
            3: return m_en[p];
            4: return m_rise[p];
            5: return m_pend[p];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input int p, input int r, input logic [31:0] d,
                                        input logic [3:0] sel);
        logic [31:0] m, dm;
        m = byte_mask(sel);
        dm = d & m;
        case (r)
            0: m_out[p]  = (m_out[p] & ~m) | dm;
            1: m_oe[p]   = (m_oe[p] & ~m) | dm;
            3: m_en[p]   = (m_en[p] & ~m) | dm;
            4: m_rise[p] = (m_rise[p] & ~m) | dm;
            5: m_pend[p] = m_pend[p] & ~dm;
            6: m_out[p]  = m_out[p] | dm;
            7: m_out[p]  = m_out[p] & ~dm;
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) begin
            m_out[p] = 0; m_oe[p] = 0; m_en[p] = 0; m_rise[p] = 0; m_pend[p] = 0;
        end
    endfunction

    function automatic logic [31:0] adr_of(input int p, input int r);
        return BASE + 32'(p) * 32'h20 + 32'(r) * 4;
    endfunction

    // Called #1 after a rising edge; returns #1 after the terminating edge.
    task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] d,
                       input logic [3:0] sel, input bit exp_err, input logic [31:0] exp_dat);
        bit got;
        exp_t e;
        e.err = exp_err;
        e.dat = exp_dat;
        sbq.push_back(e);
        wb.wb_adr_i = adr; wb.wb_dat_i = d; wb.wb_sel_i = sel; wb.wb_we_i = we;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (wb.wb_ack_o || wb.wb_err_o) begin
                got = 1;
                break;
            end
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL bus_timeout adr=%h actual=no_termination expected=termination", adr);
            if (sbq.size() > 0) void'(sbq.pop_back());
        end
    endtask

    task automatic xfer(input bit we, input logic [31:0] adr, input logic [31:0] d,
                        input logic [3:0] sel);
        logic [31:0] off, ed;
        int p, r;
        bit mapped, e;
        off = adr - BASE;
        mapped = (adr >= BASE) && (off < 32'(NP) * 32);
        p = int'(off / 32);
        r = int'((off % 32) / 4);
        e = 0;
        ed = 0;
`ifdef WB_GPIO_BANK_ERR_EN
        e = !mapped || (we && r == 2);
`endif
        if (mapped && !we && !e) ed = model_read(p, r);
        bus(we, adr, d, sel, e, ed);
        if (mapped && we && !e) model_write(p, r, d, sel);
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] eo, eoe;
        logic ei;
        eo = 0; eoe = 0; ei = 0;
        for (int p = 0; p < NP; p++) begin
            eo[p*32 +: 32] = m_out[p];
            eoe[p*32 +: 32] = m_oe[p];
            ei = ei | (|m_pend[p]);
        end
        check({tag, "_gpio_o"}, gpio_o, eo);
        check({tag, "_gpio_oe"}, gpio_oe, eoe);
        check({tag, "_irq"}, {63'd0, irq}, {63'd0, ei});
    endtask

    // Change pins, let them settle through the synchroniser, then apply the edge rules.
    task automatic pin_change(input logic [63:0] nv);
        logic [31:0] old, nw, rs, fl;
        gpio_i = nv;
        repeat (4) @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            old = m_pins[p];
            nw = nv[p*32 +: 32];
            rs = nw & ~old;
            fl = ~nw & old;
            m_pend[p] = m_pend[p] | (m_en[p] & ((m_rise[p] & rs) | (~m_rise[p] & fl)));
            m_pins[p] = nw;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        gpio_i = '0;
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
        wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        model_reset();
        for (int p = 0; p < NP; p++) m_pins[p] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {63'd0, wb.wb_ack_o}, 64'd0);
        check("rst_err", {63'd0, wb.wb_err_o}, 64'd0);
        check("rst_dat", {32'd0, wb.wb_dat_o}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state
        check_outputs("reset");
        xfer(0, adr_of(0, 0), 0, 4'hF);
        xfer(0, adr_of(0, 1), 0, 4'hF);
        xfer(0, adr_of(0, 3), 0, 4'hF);

        // Byte-gated write, set, clear
        xfer(1, adr_of(0, 0), 32'hA5A5_0000, 4'b1100);
        xfer(1, adr_of(0, 6), 32'h0000_00FF, 4'hF);
        xfer(1, adr_of(0, 7), 32'h0500_0000, 4'hF);
        xfer(0, adr_of(0, 0), 0, 4'hF);
        check("out_setclr_pins", {32'd0, gpio_o[31:0]}, {32'd0, 32'hA0A5_00FF});
        xfer(0, adr_of(0, 6), 0, 4'hF);
        check_outputs("setclr");

        // Rising edge on port1 pin 0: pending after exactly three edges
        xfer(1, adr_of(1, 3), 32'h1, 4'hF);
        xfer(1, adr_of(1, 4), 32'h1, 4'hF);
        gpio_i[32] = 1'b1;
        @(posedge clk); #1;
        check("irq_edge1", {63'd0, irq}, 64'd0);
        @(posedge clk); #1;
        check("irq_edge2", {63'd0, irq}, 64'd0);
        @(posedge clk); #1;
        check("irq_edge3", {63'd0, irq}, 64'd1);
        m_pins[1][0] = 1'b1;
        m_pend[1][0] = 1'b1;
        xfer(0, adr_of(1, 2), 0, 4'hF);
        xfer(0, adr_of(1, 5), 0, 4'hF);
        xfer(1, adr_of(1, 5), 32'h1, 4'hF);
        check("irq_w1c", {63'd0, irq}, 64'd0);
        check_outputs("w1c");

        // Falling edge landing on the same edge as a W1C of that bit
        xfer(1, adr_of(1, 4), 32'h0, 4'hF);
        gpio_i[32] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        xfer(1, adr_of(1, 5), 32'h1, 4'hF);
        m_pend[1][0] = 1'b1;
        m_pins[1][0] = 1'b0;
        check("collision_irq", {63'd0, irq}, 64'd1);
        xfer(0, adr_of(1, 5), 0, 4'hF);
        check_outputs("collision");

        // Clearing IRQ_EN keeps pending bits
        xfer(1, adr_of(1, 3), 32'h0, 4'hF);
        check("en_clear_keeps_pend", {63'd0, irq}, 64'd1);

        // Unmapped addresses and IN writes
        xfer(0, BASE + 32'h40, 0, 4'hF);
        xfer(1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
        xfer(0, BASE - 32'h4, 0, 4'hF);
        xfer(1, adr_of(0, 2), 32'hFFFF_FFFF, 4'hF);
        check_outputs("unmapped");

        // Reset between strobe and ack of an OE write
        pin_change(64'd0);
        wb.wb_adr_i = adr_of(0, 1); wb.wb_dat_i = 32'hFFFF_FFFF; wb.wb_sel_i = 4'hF;
        wb.wb_we_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        #3 rst_n = 1'b0;
        @(posedge clk); #1;
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        check("midrst_ack", {63'd0, wb.wb_ack_o}, 64'd0);
        check("midrst_irq", {63'd0, irq}, 64'd0);
        model_reset();
        check_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, adr_of(0, 1), 0, 4'hF);
        check_outputs("postrst");

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            int k, q, p;
            logic [31:0] adr;
            k = $urandom_range(0, 11);
            if (k == 0) begin
                pin_change({$urandom(), $urandom()});
            end else if (k == 1) begin
                pin_change(gpio_i ^ (64'd1 << $urandom_range(0, 63)));
            end else begin
                q = $urandom_range(0, 15);
                if (q == 15) adr = BASE - 32'($urandom_range(1, 4)) * 4;
                else begin
                    p = (q < 14) ? (q % NP) : NP;
                    adr = adr_of(p, $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                end
                xfer(1'($urandom_range(0, 1)), adr, $urandom(), 4'($urandom_range(0, 15)));
            end
            check_outputs("rand");
        end
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < 6; r++) xfer(0, adr_of(p, r), 0, 4'hF);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
